// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Combinational detector for results known at accept time (divide by zero, signed overflow).
// Optional MULDIV_ZERO_SKIP_EN also short-circuits zero operands to a zero result.
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);

  logic b_zero;
  logic a_zero;
  logic ovf;

  assign b_zero = (b_i == '0);
  assign a_zero = (a_i == '0);
  assign ovf    = (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

  always_comb begin
    special_o = 1'b0;
    result_o  = '0;
    if (is_div(op_i) && b_zero) begin
      special_o = 1'b1;
      result_o  = is_rem(op_i) ? a_i : '1;
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) && ovf) begin
      special_o = 1'b1;
      result_o  = (op_i == OP_REM) ? '0 : a_i;
    end
`ifdef MULDIV_ZERO_SKIP_EN
    else if (!is_div(op_i) && (a_zero || b_zero)) begin
      special_o = 1'b1;
      result_o  = '0;
    end else if (is_div(op_i) && a_zero) begin
      special_o = 1'b1;
      result_o  = '0;
    end
`else
    else if (a_zero && !a_zero) begin
      // Zero operands take the full iterative path in this build.
      special_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: one shift-add or restoring-division step per cycle.
// Optional MULDIV_ZERO_SKIP_EN lets zero operands bypass the iterative path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic              sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              spec_flag;
  logic [XLEN-1:0]   spec_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_mag, div_signed, fix_res;

  assign op_in = muldiv_op_e'(Funct3);
  assign sa_in = op_signed_a(op_in) & SrcA[XLEN-1];
  assign sb_in = op_signed_b(op_in) & SrcB[XLEN-1];
  assign mag_a = sa_in ? -SrcA : SrcA;
  assign mag_b = sb_in ? -SrcB : SrcB;

  muldiv_special #(.XLEN(XLEN)) u_special (
    .op_i      (op_in),
    .a_i       (SrcA),
    .b_i       (SrcB),
    .special_o (spec_flag),
    .result_o  (spec_res)
  );

  // acc holds {partial product, multiplier} or {remainder, dividend->quotient}.
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};
  assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff   = div_rem_sh - {1'b0, mcand_q};
  assign div_next   = div_diff[XLEN] ? {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  assign prod_signed = neg_q ? -acc_q : acc_q;
  assign div_mag     = is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_signed  = neg_q ? -div_mag : div_mag;

  always_comb begin
    fix_res = div_signed;
    if (!is_div(op_q)) begin
      fix_res = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = op_in;
          neg_d = is_rem(op_in) ? sa_in : (sa_in ^ sb_in);
          if (spec_flag) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = mag_b;
            cnt_d   = CNT_W'(XLEN-1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32) with hand-computed results and latencies.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
  localparam int NLAT = 34;
`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  Funct3 = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Funct3    (Funct3),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble inputs, then wait for out_valid tracking latency and busy.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input string tag, output int lat);
    int busy_bad;
    @(negedge clk);
    check({tag, " in_ready_before"}, {31'b0, in_ready}, 32'd1);
    Funct3 = f; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; Funct3 = ~f; SrcA = ~a; SrcB = b + 32'd1;
    lat = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy !== (lat < exp_lat)) busy_bad++;
    end while (!out_valid && lat < 100);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles_wrong"}, busy_bad, 32'd0);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid_after"}, {31'b0, out_valid}, 32'd0);
    check({tag, " in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    start_op(f, a, b, exp_lat, tag, lat);
    check({tag, " result"}, Result, exp);
    $display("%-14s a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, a, b, Result, lat);
    finish_op(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset Result", Result, 32'd0);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    // Normal path
    do_op(F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, NLAT, "MUL 7*-3");
    do_op(F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, NLAT, "MULH min*min");
    do_op(F_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, NLAT, "MULH -1*2");
    do_op(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NLAT, "MULHU");
    do_op(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NLAT, "MULHSU");
    do_op(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NLAT, "DIV -7/2");
    do_op(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NLAT, "REM -7/2");
    do_op(F_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, NLAT, "DIVU");
    do_op(F_REMU,   32'hFFFFFFF9, 32'd2,        32'd1,        NLAT, "REMU");
    do_op(F_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, NLAT, "DIV 100/-7");
    do_op(F_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        NLAT, "REM 100/-7");

    // Special cases
    do_op(F_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "DIVU 5/0");
    do_op(F_REM,  32'd5,        32'd0,        32'd5,        1, "REM 5/0");
    do_op(F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV ovf");
    do_op(F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "REM ovf");

    // Backpressure in DONE with in_valid pulses
    start_op(F_DIVU, 32'd5, 32'd0, 1, "BP DIVU 5/0", lat);
    held = Result;
    check("BP result", held, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      Funct3 = F_MUL; SrcA = 32'd1; SrcB = 32'd1; in_valid = (i % 2 == 0);
      @(negedge clk);
      check("BP Result stable", Result, 32'hFFFFFFFF);
      check("BP in_ready", {31'b0, in_ready}, 32'd0);
      check("BP out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    $display("%-14s held result=0x%08h for 5 cycles", "BP", held);
    finish_op("BP");

    // Reset during CALC
    @(negedge clk);
    Funct3 = F_MUL; SrcA = 32'd9; SrcB = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready}, 32'd1);
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset Result", Result, 32'd0);
    $display("%-14s reset applied 10 cycles into CALC", "MIDRESET");
    do_op(F_MUL, 32'd3, 32'd4, 32'd12, NLAT, "MUL 3*4");

    // Zero operands
    do_op(F_MUL,  32'd0, 32'd5, 32'd0, ZLAT, "MUL 0*5");
    do_op(F_DIVU, 32'd0, 32'd5, 32'd0, ZLAT, "DIVU 0/5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
